// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV into internal HI/LO,
// single-cycle MTHI/MTLO writes and combinational MFHI/MFLO reads.
module e_mdu #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Req,
    output logic        E_Busy,
    output logic [31:0] E_MDUOut
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    // Power-up values match the reset state.
    logic [31:0]   hi   = '0;
    logic [31:0]   lo   = '0;
    logic [31:0]   v1_q = '0;
    logic [31:0]   v2_q = '0;
    logic [3:0]    op_q = '0;
    logic [CW-1:0] cnt  = '0;

    logic [63:0] prod_s, prod_u;
    logic [31:0] div_b, abs_a, abs_b, q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        res_wr;

    // Result is formed from the latched operands; only sampled on the 1->0 edge.
    always_comb begin
        prod_s = $signed({{32{v1_q[31]}}, v1_q}) * $signed({{32{v2_q[31]}}, v2_q});
        prod_u = {32'd0, v1_q} * {32'd0, v2_q};
        div_b  = (v2_q == 32'd0) ? 32'd1 : v2_q;
        abs_a  = v1_q[31] ? -v1_q : v1_q;
        abs_b  = div_b[31] ? -div_b : div_b;
        q_u    = abs_a / abs_b;
        r_u    = abs_a % abs_b;
        res_hi = hi;
        res_lo = lo;
        res_wr = 1'b1;
        case (op_q)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                // Magnitude divide avoids the INT_MIN / -1 overflow corner.
                res_lo = (v1_q[31] ^ div_b[31]) ? -q_u : q_u;
                res_hi = v1_q[31] ? -r_u : r_u;
                res_wr = (v2_q != 32'd0);
            end
            OP_DIVU: begin
                res_lo = v1_q / div_b;
                res_hi = v1_q % div_b;
                res_wr = (v2_q != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            v1_q <= '0;
            v2_q <= '0;
            op_q <= '0;
            cnt  <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (!E_Req) begin
            case (E_MDUOp)
                OP_MULT, OP_MULTU: begin
                    v1_q <= E_V1;
                    v2_q <= E_V2;
                    op_q <= E_MDUOp;
                    cnt  <= CW'(MUL_CYC);
                end
                OP_DIV, OP_DIVU: begin
                    v1_q <= E_V1;
                    v2_q <= E_V2;
                    op_q <= E_MDUOp;
                    cnt  <= CW'(DIV_CYC);
                end
                OP_MTHI: hi <= E_V1;
                OP_MTLO: lo <= E_V1;
                default: ;
            endcase
        end
    end

    assign E_Busy = (cnt != '0);

    always_comb begin
        E_MDUOut = '0;
        case (E_MDUOp)
            OP_MFHI: E_MDUOut = hi;
            OP_MFLO: E_MDUOut = lo;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: reads push expected HI/LO values, a negedge
// monitor pops and compares whenever MFHI/MFLO is presented.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] E_V1 = '0;
    logic [31:0] E_V2 = '0;
    logic [3:0]  E_MDUOp = '0;
    logic        E_Req = 1'b0;
    logic        E_Busy;
    logic [31:0] E_MDUOut;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    e_mdu #(.MUL_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .E_V1     (E_V1),
        .E_V2     (E_V2),
        .E_MDUOp  (E_MDUOp),
        .E_Req    (E_Req),
        .E_Busy   (E_Busy),
        .E_MDUOut (E_MDUOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every MFHI/MFLO cycle consumes one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (E_MDUOp == 4'd5 || E_MDUOp == 4'd6) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", E_MDUOut, 32'hxxxx_xxxx);
                end else begin
                    check(name_q.pop_front(), E_MDUOut, exp_q.pop_front());
                end
            end
        end
    end

    // Called just after a posedge; presents one op for one cycle.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic req);
        E_MDUOp = op;
        E_V1    = a;
        E_V2    = b;
        E_Req   = req;
        @(posedge clk);
        #1;
        E_MDUOp = 4'd0;
        E_Req   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        drive(op, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_busy(input int exp_cyc, input string name);
        int n = 0;
        while (E_Busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check(name, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, E_Busy}, 32'd0);
        rd(4'd5, 32'h0, "reset_hi");
        rd(4'd6, 32'h0, "reset_lo");

        // MULT -2 * 3
        drive(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_busy(5, "mult_busy");
        rd(4'd5, 32'hFFFF_FFFF, "mult_hi");
        rd(4'd6, 32'hFFFF_FFFA, "mult_lo");

        // MULTU 0xFFFFFFFE * 3
        drive(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_busy(5, "multu_busy");
        rd(4'd5, 32'h0000_0002, "multu_hi");
        rd(4'd6, 32'hFFFF_FFFA, "multu_lo");

        // DIV -7 / 2
        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_busy(10, "div_busy");
        rd(4'd6, 32'hFFFF_FFFD, "div_lo");
        rd(4'd5, 32'hFFFF_FFFF, "div_hi");

        // DIV 7 / -2
        drive(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        wait_busy(10, "div2_busy");
        rd(4'd6, 32'hFFFF_FFFD, "div2_lo");
        rd(4'd5, 32'h0000_0001, "div2_hi");

        // DIVU 7 / 2
        drive(4'd4, 32'd7, 32'd2, 1'b0);
        wait_busy(10, "divu_busy");
        rd(4'd6, 32'd3, "divu_lo");
        rd(4'd5, 32'd1, "divu_hi");

        // DIVU 0xFFFFFFFF / 16
        drive(4'd4, 32'hFFFF_FFFF, 32'd16, 1'b0);
        wait_busy(10, "divu2_busy");
        rd(4'd6, 32'h0FFF_FFFF, "divu2_lo");
        rd(4'd5, 32'h0000_000F, "divu2_hi");

        // Signed overflow corner
        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_busy(10, "divovf_busy");
        rd(4'd6, 32'h8000_0000, "divovf_lo");
        rd(4'd5, 32'h0000_0000, "divovf_hi");

        // MTHI / MTLO, no busy period
        drive(4'd7, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi_busy", {31'd0, E_Busy}, 32'd0);
        drive(4'd8, 32'h9ABC_DEF0, 32'd0, 1'b0);
        check("mtlo_busy", {31'd0, E_Busy}, 32'd0);
        rd(4'd5, 32'h1234_5678, "mt_hi");
        rd(4'd6, 32'h9ABC_DEF0, "mt_lo");

        // Divide by zero keeps HI/LO
        drive(4'd8, 32'h0000_0055, 32'd0, 1'b0);
        drive(4'd3, 32'd100, 32'd0, 1'b0);
        wait_busy(10, "div0_busy");
        rd(4'd6, 32'h0000_0055, "div0_lo");
        rd(4'd5, 32'h1234_5678, "div0_hi");

        // E_Req blocks start and MT writes
        drive(4'd1, 32'd5, 32'd6, 1'b1);
        wait_busy(0, "req_mult_busy");
        drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1);
        rd(4'd5, 32'h1234_5678, "req_hi");
        rd(4'd6, 32'h0000_0055, "req_lo");

        // Op codes above 8 act as NONE
        drive(4'd12, 32'hCAFE_F00D, 32'd3, 1'b0);
        check("op12_busy", {31'd0, E_Busy}, 32'd0);

        // Ops while busy are ignored
        drive(4'd1, 32'd10, 32'd20, 1'b0);
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drive(4'd8, 32'h7777_7777, 32'd0, 1'b0);
        wait_busy(3, "busy_ignore_busy");
        rd(4'd5, 32'h0000_0000, "busy_ignore_hi");
        rd(4'd6, 32'h0000_00C8, "busy_ignore_lo");

        // Reset in cycle 3 of a DIV
        drive(4'd8, 32'h1111_1111, 32'd0, 1'b0);
        drive(4'd3, 32'd100, 32'd7, 1'b0);
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        check("pre_reset_busy", {31'd0, E_Busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset_busy", {31'd0, E_Busy}, 32'd0);
        rd(4'd5, 32'h0, "midreset_hi");
        rd(4'd6, 32'h0, "midreset_lo");
        repeat (12) drive(4'd0, 32'd0, 32'd0, 1'b0);
        rd(4'd5, 32'h0, "discard_hi");
        rd(4'd6, 32'h0, "discard_lo");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL expose ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- E_V1  in  32  rs operand, post-forwarding
- E_V2  in  32  rt operand, post-forwarding
- E_MDUOp  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- E_Req  in  1  exception/interrupt taken this cycle; suppresses state change by the E-stage instruction
- E_Busy  out  1  multi-cycle operation in flight
- E_MDUOut  out  32  MFHI/MFLO read data
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL keep HI and LO as internal 32-bit registers, not ports.
REQ-004 SHALL have parameters (name, default, meaning): MUL_CYC, 5, multiply busy cycles; DIV_CYC, 10, divide busy cycles.

Function
REQ-005 SHALL define "start" as E_MDUOp in {1..4} && !E_Busy && !E_Req in the same cycle.
REQ-006 On start, SHALL latch the operands and op at the clock edge, then load the cycle counter with MUL_CYC (ops 1,2) or DIV_CYC (ops 3,4).
REQ-007 SHALL drive E_Busy = (counter != 0); E_Busy is high for exactly MUL_CYC or DIV_CYC cycles, starting the cycle after start.
REQ-008 SHALL decrement the counter by one on each edge while it is nonzero.
REQ-009 SHALL write HI/LO with the latched result at the edge where the counter goes 1->0; new values are visible in the first cycle E_Busy is low.
REQ-010 MULT SHALL produce the signed 64-bit product {HI,LO} = $signed(V1)*$signed(V2); MULTU SHALL produce the unsigned product.
REQ-011 DIV SHALL produce LO = signed quotient truncated toward zero and HI = remainder with the sign of the dividend; DIVU SHALL produce the unsigned quotient and remainder.
REQ-012 Division by zero SHALL complete with normal busy timing and leave HI and LO unchanged.
REQ-013 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-014 MTHI/MTLO SHALL write E_V1 to HI/LO at the edge, with no busy period, and only when !E_Busy && !E_Req.
REQ-015 E_MDUOut SHALL be combinational: HI when op=5, LO when op=6, else 0; during busy it returns the pre-operation HI/LO value (the upstream stall unit guarantees no read in that window).
REQ-016 When E_Busy is high, ops 1-4 and 7-8 SHALL be ignored: no restart and no HI/LO write.
REQ-017 E_Req SHALL NOT cancel an operation already in flight; it only blocks a start or MT write in the same cycle.
REQ-018 When a start and the counter's 1->0 edge coincide, this is impossible by REQ-005; no arbitration is required.

Reset
REQ-019 reset high at an edge SHALL clear HI, LO, the counter, and the latched operands/op to 0, giving E_Busy=0 and E_MDUOut=0 in the next cycle when op=NONE.
REQ-020 reset SHALL take priority over start, MT writes, and completion, including mid-operation; the aborted result is discarded.
REQ-021 With no reset applied, initial state SHALL equal the reset state.

Verification
REQ-022 MULT V1=0xFFFFFFFE (-2), V2=3 -> E_Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-023 DIV V1=-7 (0xFFFFFFF9), V2=2 -> E_Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1.
REQ-024 MTHI 0x12345678, then MTLO 0x9ABCDEF0, then MFHI and MFLO -> E_MDUOut=0x12345678, then 0x9ABCDEF0, with no busy.
REQ-025 DIV by 0 after MTLO 0x55 -> E_Busy high 10 cycles, LO stays 0x55; E_Req=1 with MULT -> E_Busy stays 0 and HI/LO unchanged.
REQ-026 reset asserted in cycle 3 of a DIV -> E_Busy=0 next cycle, HI=LO=0; MULT issued while busy -> ignored, and the result matches the first operation only.
